// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the round-robin serial pattern-match scheduler.
package seq_sched_pkg;

    localparam int unsigned PAT_LEN = 3;
    localparam logic [PAT_LEN-1:0] DEFAULT_PATTERN = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SHIFT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/seq_det_core.sv
// Overlapping serial pattern detector with a Mealy match output.
// The history only counts as valid once PAT_LEN-1 bits have arrived since the last clear.
module seq_det_core
    import seq_sched_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic w,
    output logic z
);

    localparam int unsigned HW = PAT_LEN - 1;
    localparam int unsigned FW = $clog2(PAT_LEN);

    logic [HW-1:0] r_hist;
    logic [FW-1:0] r_fill;

    assign z = (r_fill == FW'(HW)) && ({r_hist, w} == PATTERN);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= HW'({r_hist, w});
            if (r_fill != FW'(HW)) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_match_sched.sv
// Round-robin arbiter that serialises the winner's word MSB first through the
// pattern detector and reports the number of matches with the winner's index.
module serial_match_sched
    import seq_sched_pkg::*;
#(
    parameter int unsigned        NREQ    = 4,
    parameter int unsigned        WIDTH   = 8,
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [$clog2(WIDTH):0]  match_cnt
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;
    localparam int unsigned BCW = $clog2(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_winner, w_winner_nxt;
    logic [WIDTH-1:0] r_word, w_word_nxt;
    logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [IDW-1:0]   r_done_id, w_done_id_nxt;

    logic             w_found;
    logic [IDW-1:0]   w_arb;
    logic [IDW-1:0]   w_idx;
    logic [WIDTH-1:0] w_sel_word;
    logic             w_clr;
    logic             w_z;

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_cnt;

    assign w_sel_word = WIDTH'(data >> (r_winner * WIDTH));

    // Round-robin search: first asserted request at or after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_arb   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_arb   = w_idx;
            end
        end
    end

    seq_det_core #(
        .PATTERN(PATTERN)
    ) u_det (
        .Clk(Clk),
        .Rst(Rst),
        .clr(w_clr),
        .w  (r_word[WIDTH-1]),
        .z  (w_z)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_winner  <= w_winner_nxt;
            r_word    <= w_word_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
        end
    end

    // Sequencing FSM; registered outputs are computed one cycle ahead of their state.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_winner_nxt  = r_winner;
        w_word_nxt    = r_word;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = '0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_clr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_winner_nxt = w_arb;
                    w_ptr_nxt    = IDW'((32'(w_arb) + 1) % NREQ);
                    w_grant_nxt  = NREQ'(1) << w_arb;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            S_GRANT: begin
                w_state_nxt   = S_SHIFT;
                w_word_nxt    = w_sel_word;
                w_bit_cnt_nxt = '0;
                w_clr         = 1'b1;
            end
            S_SHIFT: begin
                w_word_nxt = r_word << 1;
                if (w_z) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if (r_bit_cnt == BCW'(WIDTH - 1)) begin
                    w_state_nxt   = S_REPORT;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_winner;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                end
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_match_sched.sv
// Randomised scoreboard bench for serial_match_sched against a word-level reference model.
module tb_serial_match_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam logic [2:0]  PAT   = 3'b101;

    typedef struct {
        logic [NREQ-1:0] g;
        int              id;
        int              cnt;
        int              s;
    } exp_t;

    logic                  Clk = 1'b0;
    logic                  Rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [1:0]            done_id;
    logic [3:0]            match_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_ptr    = 0;
    bit   at_report = 1'b0;
    bit   chk_idle  = 1'b0;
    exp_t gq[$];
    exp_t dq[$];

    serial_match_sched #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .PATTERN(PAT)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .match_cnt(match_cnt)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Count overlapping occurrences of PAT scanning the word MSB first.
    function automatic int model_cnt(input logic [WIDTH-1:0] w);
        int n = 0;
        for (int i = WIDTH - 1; i >= 2; i--) begin
            if ({w[i], w[i-1], w[i-2]} == PAT) n++;
        end
        return n;
    endfunction

    // mode 0: garbage on req/data after grant; mode 1: data forced to zero after latch;
    // mode 2: reset pulse during the fourth bit of the serial phase.
    task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input int mode);
        exp_t            e;
        int              s;
        int              win;
        logic [WIDTH-1:0] w;
        s   = at_report ? cyc + 1 : cyc;
        req  = r;
        data = d;
        win = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (win < 0 && r[i]) win = i;
        end
        m_ptr = (win + 1) % NREQ;
        w     = d[win*WIDTH +: WIDTH];
        e.g   = NREQ'(1) << win;
        e.id  = win;
        e.cnt = model_cnt(w);
        e.s   = s;
        gq.push_back(e);
        dq.push_back(e);
        forever begin
            @(negedge Clk);
            if (mode == 2 && cyc == s + 5) begin
                Rst = 1'b1;
                req = '0;
                @(negedge Clk);
                chk("abort_busy", busy, 0);
                chk("abort_match_cnt", match_cnt, 0);
                chk("abort_done", done, 0);
                chk("abort_done_id", done_id, 0);
                chk("abort_grant", grant, 0);
                Rst = 1'b0;
                void'(dq.pop_back());
                m_ptr     = 0;
                at_report = 1'b0;
                return;
            end
            if (done) begin
                at_report = 1'b1;
                return;
            end
            if (cyc >= s + 2 && cyc <= s + int'(WIDTH) + 1) begin
                if (mode == 1) begin
                    data = '0;
                end else if (mode == 0) begin
                    req  = NREQ'($urandom);
                    data = $urandom;
                end
            end
            if (cyc > s + int'(WIDTH) + 10) begin
                chk("done_timeout", 1, 0);
                at_report = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        req = '0;
        repeat (n) @(negedge Clk);
        at_report = 1'b0;
    endtask

    // Monitor: pops expected responses whenever the DUT presents a grant or result.
    always @(negedge Clk) begin
        if (Rst) begin
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("busy_idle_gap", busy, 0);
                chk_idle = 1'b0;
            end
            if (grant != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    chk("grant_vec", grant, e.g);
                    chk("grant_cycle", cyc, e.s + 1);
                    chk("busy_at_grant", busy, 1);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("match_cnt", match_cnt, e.cnt);
                    chk("done_cycle", cyc, e.s + int'(WIDTH) + 2);
                    chk("busy_at_done", busy, 1);
                end
                chk_idle = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        logic [NREQ-1:0]       r;
        Rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (3) @(negedge Clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_match_cnt", match_cnt, 0);
        Rst = 1'b0;

        d = '0;
        d[7:0] = 8'b10101010;
        run_txn(4'b0001, d, 0);
        d = $urandom;
        d[23:16] = 8'hFF;
        run_txn(4'b0100, d, 0);

        d = $urandom;
        d[31:24] = 8'b00000010;
        run_txn(4'b1000, d, 0);
        d = $urandom;
        d[31:24] = 8'b10000000;
        run_txn(4'b1000, d, 0);

        d = $urandom;
        d[15:8] = 8'b10110101;
        run_txn(4'b0010, d, 1);

        d = $urandom;
        d[15:8] = 8'b10101010;
        run_txn(4'b0010, d, 2);
        idle_cycles(2);

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            run_txn(4'b1111, d, 0);
        end
        idle_cycles(3);

        for (int i = 0; i < 40; i++) begin
            r = NREQ'($urandom_range(0, 15));
            d = $urandom;
            if (r == '0) begin
                idle_cycles($urandom_range(1, 3));
            end else if ($urandom_range(0, 9) == 0) begin
                run_txn(r, d, 2);
                idle_cycles(1);
            end else begin
                run_txn(r, d, $urandom_range(0, 1));
            end
        end
        idle_cycles(WIDTH + 4);
        chk("grant_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
